// File: rtl/lock_reg_read_port.sv
// Read port for a bank of lockable config registers: 4-phase req/ack, locked data
// only to trusted requesters. Optional audit outputs under LOCK_READ_AUDIT_EN.
module lock_reg_read_port #(
    parameter int                 NUM_REGS   = 4,
    parameter int                 ADDR_W     = 2,
    parameter int                 DATA_W     = 16,
    parameter logic [DATA_W-1:0]  MASK_VALUE = 16'h0000,
    parameter int                 CNT_W      = 8
) (
    input  logic                         Clk,
    input  logic                         resetn,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
    input  logic [NUM_REGS-1:0]          reg_lock,
    input  logic                         rd_req,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic                         rd_trusted,
    input  logic                         cnt_clr,
    output logic                         rd_ack,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_err,
    output logic [CNT_W-1:0]             viol_count
`ifdef LOCK_READ_AUDIT_EN
    ,
    output logic [ADDR_W-1:0]            viol_addr,
    output logic                         viol_sticky
`endif
);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    // One extra bit so the range check also works when NUM_REGS == 2**ADDR_W.
    localparam int              NUM_REGS_I = NUM_REGS;
    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS_I[ADDR_W:0];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                trusted_q, trusted_d;
    logic                rd_ack_q, rd_ack_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_err_q, rd_err_d;
    logic [CNT_W-1:0]    viol_count_q, viol_count_d;
    logic                viol_inc;
    logic                in_range;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_lock;
`ifdef LOCK_READ_AUDIT_EN
    logic [ADDR_W-1:0]   viol_addr_q, viol_addr_d;
    logic                viol_sticky_q, viol_sticky_d;
`endif

    always_comb begin
        in_range = ({1'b0, addr_q} < NUM_REGS_W);
        sel_data = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == i[ADDR_W-1:0]) begin
                sel_data = reg_data[i*DATA_W +: DATA_W];
                sel_lock = reg_lock[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        trusted_d    = trusted_q;
        rd_ack_d     = 1'b0;
        rd_data_d    = rd_data_q;
        rd_err_d     = rd_err_q;
        viol_inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    addr_d    = rd_addr;
                    trusted_d = rd_trusted;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (!rd_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                    if (!in_range) begin
                        rd_data_d = MASK_VALUE;
                        rd_err_d  = 1'b1;
                    end else if (sel_lock && !trusted_q) begin
                        rd_data_d = MASK_VALUE;
                        rd_err_d  = 1'b1;
                        viol_inc  = 1'b1;
                    end else begin
                        rd_data_d = sel_data;
                        rd_err_d  = 1'b0;
                    end
                end
            end
            RESP: begin
                if (rd_req) rd_ack_d = 1'b1;
                else        state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear beats a same-cycle increment; saturate rather than wrap.
        viol_count_d = viol_count_q;
        if (cnt_clr)                            viol_count_d = '0;
        else if (viol_inc && viol_count_q != '1) viol_count_d = viol_count_q + 1'b1;

`ifdef LOCK_READ_AUDIT_EN
        viol_addr_d   = viol_addr_q;
        viol_sticky_d = viol_sticky_q;
        if (cnt_clr) begin
            viol_addr_d   = '0;
            viol_sticky_d = 1'b0;
        end else if (viol_inc) begin
            viol_addr_d   = addr_q;
            viol_sticky_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            trusted_q     <= 1'b0;
            rd_ack_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_err_q      <= 1'b0;
            viol_count_q  <= '0;
`ifdef LOCK_READ_AUDIT_EN
            viol_addr_q   <= '0;
            viol_sticky_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            trusted_q     <= trusted_d;
            rd_ack_q      <= rd_ack_d;
            rd_data_q     <= rd_data_d;
            rd_err_q      <= rd_err_d;
            viol_count_q  <= viol_count_d;
`ifdef LOCK_READ_AUDIT_EN
            viol_addr_q   <= viol_addr_d;
            viol_sticky_q <= viol_sticky_d;
`endif
        end
    end

    assign rd_ack     = rd_ack_q;
    assign rd_data    = rd_data_q;
    assign rd_err     = rd_err_q;
    assign viol_count = viol_count_q;
`ifdef LOCK_READ_AUDIT_EN
    assign viol_addr   = viol_addr_q;
    assign viol_sticky = viol_sticky_q;
`endif

endmodule

// File: tb/tb_lock_reg_read_port.sv
// Bench for lock_reg_read_port with a 3-register bank so address 3 is out of range;
// directed handshake/reset/saturation steps plus randomized reads against a policy model.
module tb_lock_reg_read_port;

    localparam int NR = 3;
    localparam int AW = 2;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam logic [DW-1:0] MASK = 16'h0000;

    logic              Clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NR*DW-1:0]  reg_data = '0;
    logic [NR-1:0]     reg_lock = '0;
    logic              rd_req = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic              rd_trusted = 1'b0;
    logic              cnt_clr = 1'b0;
    logic              rd_ack;
    logic [DW-1:0]     rd_data;
    logic              rd_err;
    logic [CW-1:0]     viol_count;

    lock_reg_read_port #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .MASK_VALUE(MASK), .CNT_W(CW)) dut (
        .Clk(Clk), .resetn(resetn), .reg_data(reg_data), .reg_lock(reg_lock),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_trusted(rd_trusted), .cnt_clr(cnt_clr),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err), .viol_count(viol_count)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic [DW-1:0] last_data = '0;
    logic          last_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Policy model: out-of-range -> mask+err; locked & untrusted -> mask+err+count; else data.
    task automatic read_txn(input logic [AW-1:0] a, input logic t, input logic clr, input logic poke);
        int n;
        logic [DW-1:0] ed;
        logic ee;
        logic viol;
        viol = 1'b0;
        if (int'(a) >= NR) begin
            ed = MASK; ee = 1'b1;
        end else if (reg_lock[a] && !t) begin
            ed = MASK; ee = 1'b1; viol = 1'b1;
        end else begin
            ed = reg_data[int'(a)*DW +: DW]; ee = 1'b0;
        end
        if (clr)       model_cnt = 0;
        else if (viol) model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;

        @(negedge Clk);
        rd_addr = a; rd_trusted = t; rd_req = 1'b1;
        n = 0;
        while (!rd_ack && n < 8) begin
            @(negedge Clk);
            n++;
            cnt_clr = (n == 1) ? clr : 1'b0;
        end
        cnt_clr = 1'b0;
        chk("ack_latency", 32'(n), 32'd3);
        chk("rd_data", 32'(rd_data), 32'(ed));
        chk("rd_err", 32'(rd_err), 32'(ee));
        chk("viol_count", 32'(viol_count), 32'(model_cnt));
        if (poke) begin
            reg_data = ~reg_data;
            reg_lock = ~reg_lock;
            @(negedge Clk);
            chk("snapshot_data", 32'(rd_data), 32'(ed));
            chk("snapshot_err", 32'(rd_err), 32'(ee));
            chk("ack_hold", 32'(rd_ack), 32'd1);
        end
        rd_req = 1'b0;
        @(negedge Clk);
        chk("ack_drop", 32'(rd_ack), 32'd0);
        chk("data_hold", 32'(rd_data), 32'(ed));
        last_data = ed;
        last_err  = ee;
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        chk("rst_ack", 32'(rd_ack), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_err", 32'(rd_err), 32'd0);
        chk("rst_cnt", 32'(viol_count), 32'd0);
        @(negedge Clk);
        resetn = 1'b1;

        // Unlocked read, locked untrusted, locked trusted with snapshot poke
        reg_data = {16'hA5A5, 16'h1234, 16'h0F0F};
        reg_lock = 3'b000;
        read_txn(2'd2, 1'b0, 1'b0, 1'b0);
        reg_lock = 3'b010;
        read_txn(2'd1, 1'b0, 1'b0, 1'b0);
        read_txn(2'd1, 1'b1, 1'b0, 1'b1);
        reg_data = {16'hA5A5, 16'h1234, 16'h0F0F};
        reg_lock = 3'b010;

        // Out-of-range address
        read_txn(2'd3, 1'b0, 1'b0, 1'b0);

        // Premature drop in CHECK: no ack, no count
        @(negedge Clk);
        rd_addr = 2'd1; rd_trusted = 1'b0; rd_req = 1'b1;
        @(negedge Clk);
        rd_req = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk("drop_no_ack", 32'(rd_ack), 32'd0);
        end
        chk("drop_cnt", 32'(viol_count), 32'(model_cnt));
        chk("drop_data_hold", 32'(rd_data), 32'(last_data));
        chk("drop_err_hold", 32'(rd_err), 32'(last_err));

        // Randomized reads
        for (int k = 0; k < 40; k++) begin
            reg_data = {16'($urandom), 16'($urandom), 16'($urandom)};
            reg_lock = 3'($urandom);
            read_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        // Saturation, then clear coincident with a violation
        reg_lock = 3'b111;
        read_txn(2'd0, 1'b0, 1'b1, 1'b0);
        repeat (256) read_txn(2'd0, 1'b0, 1'b0, 1'b0);
        chk("sat_255", 32'(viol_count), 32'd255);
        read_txn(2'd0, 1'b0, 1'b1, 1'b0);
        chk("clr_wins", 32'(viol_count), 32'd0);
        read_txn(2'd2, 1'b0, 1'b0, 1'b0);

        // Reset while in RESP, then a fresh transaction with rd_req held
        reg_lock = 3'b000;
        reg_data = {16'hBEEF, 16'h1234, 16'h0F0F};
        @(negedge Clk);
        rd_addr = 2'd2; rd_trusted = 1'b1; rd_req = 1'b1;
        n = 0;
        while (!rd_ack && n < 8) begin @(negedge Clk); n++; end
        chk("pre_rst_ack", 32'(rd_ack), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(rd_ack), 32'd0);
        chk("mid_rst_data", 32'(rd_data), 32'd0);
        chk("mid_rst_err", 32'(rd_err), 32'd0);
        chk("mid_rst_cnt", 32'(viol_count), 32'd0);
        model_cnt = 0;
        @(negedge Clk);
        resetn = 1'b1;
        n = 0;
        while (!rd_ack && n < 8) begin @(negedge Clk); n++; end
        chk("post_rst_latency", 32'(n), 32'd3);
        chk("post_rst_data", 32'(rd_data), 32'h0000BEEF);
        rd_req = 1'b0;
        @(negedge Clk);
        chk("post_rst_drop", 32'(rd_ack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
